// File: rtl/dtim_arbiter.sv
// dtim_arbiter: shares one dtim port between the instruction-fetch requester
// and the data load/store requester. Each requester gets one pending slot;
// pending requests are granted one at a time (fixed-priority or round-robin)
// and the dtim response is steered back combinationally to the owner.
module dtim_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1   // 1: alternate on contention, 0: data always wins
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic        dtim_valid,
   output logic        dtim_instr,
   output logic [31:0] dtim_addr,
   output logic [31:0] dtim_wdata,
   output logic [3:0]  dtim_wstrb,
   input  logic [31:0] dtim_rdata,
   input  logic        dtim_ready
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef struct packed {
      logic        v;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } dslot_t;

   logic [0:0]  state;
   logic        islot_v;
   logic [31:0] islot_addr;
   dslot_t      dslot;
   logic        owner;
   logic        last_grant;

   logic        busy;
   logic        resp_i, resp_d;
   logic        i_acc, d_acc;
   logic        icand, dcand;
   logic        win;
   logic        pick_d;
   logic        grant_i, grant_d;
   logic [31:0] i_addr;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;

   assign busy = (state == BUSY);

   // Response routing is zero-cycle; a dtim_ready while IDLE belongs to nobody.
   assign resp_i     = dtim_ready & busy & (owner == OWN_I);
   assign resp_d     = dtim_ready & busy & (owner == OWN_D);
   assign imem_ready = resp_i;
   assign dmem_ready = resp_d;
   assign imem_rdata = dtim_rdata;
   assign dmem_rdata = dtim_rdata;

   // A requester is outstanding while its slot is full or it owns the dtim.
   // A new pulse is taken only if nothing is outstanding, or its in-flight
   // request is being answered this very cycle (back-to-back issue).
   assign i_acc = imem_valid & (~(islot_v | (busy & (owner == OWN_I))) | resp_i);
   assign d_acc = dmem_valid & (~(dslot.v | (busy & (owner == OWN_D))) | resp_d);

   // Candidates include a pulse arriving this cycle so it can bypass the slot.
   assign icand = islot_v | i_acc;
   assign dcand = dslot.v | d_acc;

   assign i_addr  = islot_v ? islot_addr  : imem_addr;
   assign d_addr  = dslot.v ? dslot.addr  : dmem_addr;
   assign d_wdata = dslot.v ? dslot.wdata : dmem_wdata;
   assign d_wstrb = dslot.v ? dslot.wstrb : dmem_wstrb;

   // Arbitration window: dtim free now, or freed by the response this cycle.
   assign win     = ~busy | dtim_ready;
   assign pick_d  = dcand & (~icand | (ROUND_ROBIN == 1'b0) | (last_grant == OWN_I));
   assign grant_d = win & pick_d;
   assign grant_i = win & icand & ~pick_d;

   // Slot capture, grant bookkeeping and the registered dtim request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         islot_v    <= 1'b0;
         dslot.v    <= 1'b0;
         owner      <= OWN_D;
         last_grant <= OWN_D;
         dtim_valid <= 1'b0;
         dtim_instr <= 1'b0;
         dtim_addr  <= '0;
         dtim_wdata <= '0;
         dtim_wstrb <= '0;
      end else begin
         dtim_valid <= 1'b0;

         if (grant_i) begin
            islot_v <= 1'b0;
         end else if (i_acc) begin
            islot_v    <= 1'b1;
            islot_addr <= imem_addr;
         end

         if (grant_d) begin
            dslot.v <= 1'b0;
         end else if (d_acc) begin
            dslot.v     <= 1'b1;
            dslot.addr  <= dmem_addr;
            dslot.wdata <= dmem_wdata;
            dslot.wstrb <= dmem_wstrb;
         end

         if (win) begin
            if (grant_i | grant_d) begin
               state      <= BUSY;
               dtim_valid <= 1'b1;
               owner      <= grant_d ? OWN_D : OWN_I;
               last_grant <= grant_d ? OWN_D : OWN_I;
               dtim_instr <= grant_i;
               dtim_addr  <= grant_d ? d_addr  : i_addr;
               dtim_wdata <= grant_d ? d_wdata : 32'h0;
               dtim_wstrb <= grant_d ? d_wstrb : 4'h0;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_dtim_arbiter.sv
// tb_dtim_arbiter: table of per-cycle stimulus/expectations for the
// round-robin instance, plus a hand sequence for fixed-priority contention.
module tb_dtim_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_valid, dmem_valid, dtim_ready;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata, dtim_rdata;
   logic [3:0]  dmem_wstrb;

   logic [31:0] irdata1, drdata1, addr1, wdata1, irdata0, drdata0, addr0, wdata0;
   logic        iready1, dready1, valid1, instr1, iready0, dready0, valid0, instr0;
   logic [3:0]  wstrb1, wstrb0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dtim_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(irdata1), .imem_ready(iready1),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(drdata1), .dmem_ready(dready1),
      .dtim_valid(valid1), .dtim_instr(instr1), .dtim_addr(addr1), .dtim_wdata(wdata1),
      .dtim_wstrb(wstrb1), .dtim_rdata(dtim_rdata), .dtim_ready(dtim_ready)
   );

   dtim_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(irdata0), .imem_ready(iready0),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(drdata0), .dmem_ready(dready0),
      .dtim_valid(valid0), .dtim_instr(instr0), .dtim_addr(addr0), .dtim_wdata(wdata0),
      .dtim_wstrb(wstrb0), .dtim_rdata(dtim_rdata), .dtim_ready(dtim_ready)
   );

   typedef struct {
      logic        rst, iv, dv, rdy;
      logic [31:0] ia, da, dw, rd;
      logic [3:0]  ds;
      logic        e_v, e_ir, e_dr, chk, e_instr;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_wstrb;
   } vec_t;

   localparam int NV = 32;
   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                               logic [31:0] dw, logic [3:0] ds, logic rdy, logic [31:0] rd,
                               logic ev, logic eir, logic edr, logic chk, logic ei,
                               logic [31:0] ea, logic [31:0] ew, logic [3:0] es);
      vec_t v;
      v.rst = r; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.ds = ds;
      v.rdy = rdy; v.rd = rd; v.e_v = ev; v.e_ir = eir; v.e_dr = edr; v.chk = chk;
      v.e_instr = ei; v.e_addr = ea; v.e_wdata = ew; v.e_wstrb = es;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge; outputs are then
   // sampled mid-cycle by the caller.
   task automatic drive(input vec_t v);
      @(posedge clk);
      #1;
      rst = v.rst; imem_valid = v.iv; imem_addr = v.ia;
      dmem_valid = v.dv; dmem_addr = v.da; dmem_wdata = v.dw; dmem_wstrb = v.ds;
      dtim_ready = v.rdy; dtim_rdata = v.rd;
      #4;
   endtask

   initial begin
      // rst iv ia dv da dw ds rdy rd | e_v e_ir e_dr chk instr addr wdata wstrb
      // single load
      tbl[0]  = mk(1,0,0,     0,0,0,0,           0,0,            0,0,0, 1,0,0,0,0);
      tbl[1]  = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 1,0,0,0,0);
      tbl[2]  = mk(0,0,0,     1,'h100,0,0,       0,0,            0,0,0, 0,0,0,0,0);
      tbl[3]  = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,0,'h100,0,0);
      tbl[4]  = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 1,0,'h100,0,0);
      tbl[5]  = mk(0,0,0,     0,0,0,0,           1,'hDEADBEEF,   0,0,1, 1,0,'h100,0,0);
      tbl[6]  = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);
      tbl[7]  = mk(0,0,0,     0,0,0,0,           1,'h12,         0,0,0, 0,0,0,0,0);
      // contention, last grant was data -> fetch first
      tbl[8]  = mk(0,1,0,     1,'h200,'h12345678,4'hF, 0,0,      0,0,0, 0,0,0,0,0);
      tbl[9]  = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,1,0,0,0);
      tbl[10] = mk(0,0,0,     0,0,0,0,           1,'hA5A50000,   0,1,0, 1,1,0,0,0);
      tbl[11] = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,0,'h200,'h12345678,4'hF);
      tbl[12] = mk(0,0,0,     0,0,0,0,           1,'h11112222,   0,0,1, 1,0,'h200,'h12345678,4'hF);
      // back-to-back fetch
      tbl[13] = mk(0,1,0,     0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);
      tbl[14] = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,1,0,0,0);
      tbl[15] = mk(0,1,'h4,   0,0,0,0,           1,'hCAFE0000,   0,1,0, 1,1,0,0,0);
      tbl[16] = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,1,'h4,0,0);
      tbl[17] = mk(0,0,0,     0,0,0,0,           1,'hCAFE0004,   0,1,0, 1,1,'h4,0,0);
      // second data pulse while first is still in its slot is dropped
      tbl[18] = mk(0,1,'h8,   0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);
      tbl[19] = mk(0,0,0,     1,'h200,0,0,       0,0,            1,0,0, 1,1,'h8,0,0);
      tbl[20] = mk(0,0,0,     1,'h300,0,0,       0,0,            0,0,0, 1,1,'h8,0,0);
      tbl[21] = mk(0,0,0,     0,0,0,0,           1,'h88,         0,1,0, 1,1,'h8,0,0);
      tbl[22] = mk(0,0,0,     0,0,0,0,           0,0,            1,0,0, 1,0,'h200,0,0);
      tbl[23] = mk(0,0,0,     0,0,0,0,           1,'h200200,     0,0,1, 1,0,'h200,0,0);
      tbl[24] = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 1,0,'h200,0,0);
      tbl[25] = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);
      // reset while busy with a data request queued
      tbl[26] = mk(0,1,'hC,   0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);
      tbl[27] = mk(0,0,0,     1,'h400,'h5555,4'hF, 0,0,          1,0,0, 1,1,'hC,0,0);
      tbl[28] = mk(1,0,0,     0,0,0,0,           0,0,            0,0,0, 1,1,'hC,0,0);
      tbl[29] = mk(0,0,0,     0,0,0,0,           1,'h99,         0,0,0, 1,0,0,0,0);
      tbl[30] = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 1,0,0,0,0);
      tbl[31] = mk(0,0,0,     0,0,0,0,           0,0,            0,0,0, 0,0,0,0,0);

      rst = 1'b1; imem_valid = 0; dmem_valid = 0; dtim_ready = 0;
      imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0; dtim_rdata = 0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         cmp($sformatf("row%0d dtim_valid", i), {31'b0, valid1},  {31'b0, tbl[i].e_v});
         cmp($sformatf("row%0d imem_ready", i), {31'b0, iready1}, {31'b0, tbl[i].e_ir});
         cmp($sformatf("row%0d dmem_ready", i), {31'b0, dready1}, {31'b0, tbl[i].e_dr});
         if (tbl[i].e_ir) cmp($sformatf("row%0d imem_rdata", i), irdata1, tbl[i].rd);
         if (tbl[i].e_dr) cmp($sformatf("row%0d dmem_rdata", i), drdata1, tbl[i].rd);
         if (tbl[i].chk) begin
            cmp($sformatf("row%0d dtim_instr", i), {31'b0, instr1}, {31'b0, tbl[i].e_instr});
            cmp($sformatf("row%0d dtim_addr", i),  addr1,  tbl[i].e_addr);
            cmp($sformatf("row%0d dtim_wdata", i), wdata1, tbl[i].e_wdata);
            cmp($sformatf("row%0d dtim_wstrb", i), {28'b0, wstrb1}, {28'b0, tbl[i].e_wstrb});
         end
      end

      // Fixed priority: same contention stimulus, data must go first.
      drive(mk(1,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
      drive(mk(0,1,0, 1,'h200,'h12345678,4'hF, 0,0, 0,0,0,0,0,0,0,0));
      cmp("fp idle dtim_valid", {31'b0, valid0}, 32'd0);
      drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
      cmp("fp first dtim_valid", {31'b0, valid0}, 32'd1);
      cmp("fp first dtim_instr", {31'b0, instr0}, 32'd0);
      cmp("fp first dtim_addr",  addr0,  32'h200);
      cmp("fp first dtim_wdata", wdata0, 32'h12345678);
      cmp("fp first dtim_wstrb", {28'b0, wstrb0}, 32'hF);
      drive(mk(0,0,0, 0,0,0,0, 1,'h77,  0,0,0,0,0,0,0,0));
      cmp("fp first dmem_ready", {31'b0, dready0}, 32'd1);
      cmp("fp first imem_ready", {31'b0, iready0}, 32'd0);
      cmp("fp first dmem_rdata", drdata0, 32'h77);
      drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
      cmp("fp second dtim_valid", {31'b0, valid0}, 32'd1);
      cmp("fp second dtim_instr", {31'b0, instr0}, 32'd1);
      cmp("fp second dtim_addr",  addr0,  32'h0);
      cmp("fp second dtim_wstrb", {28'b0, wstrb0}, 32'h0);
      cmp("fp second dtim_wdata", wdata0, 32'h0);
      drive(mk(0,0,0, 0,0,0,0, 1,'h66,  0,0,0,0,0,0,0,0));
      cmp("fp second imem_ready", {31'b0, iready0}, 32'd1);
      cmp("fp second dmem_ready", {31'b0, dready0}, 32'd0);
      cmp("fp second imem_rdata", irdata0, 32'h66);
      drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,0,0,0));
      cmp("fp after dtim_valid", {31'b0, valid0}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dtim_arbiter.md
Name: dtim_arbiter

Overview:
- Shares the single dtim port between the core's instruction-fetch requester and its data load/store requester.
- Each requester's one-cycle request pulse is captured into its own pending slot.
- Pending requests are granted one at a time, fixed-priority or round-robin, and each response is routed back to the owning requester.
- Sits between the core's imem/dmem interfaces and the dtim.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grants on contention (last-granted loses); 0 = data requester always wins.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_valid  in  1  instruction request pulse (one cycle)
- imem_addr  in  32  instruction address
- imem_rdata  out  32  instruction read data
- imem_ready  out  1  instruction response pulse
- dmem_valid  in  1  data request pulse (one cycle)
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte strobes; 0 = load
- dmem_rdata  out  32  data read data
- dmem_ready  out  1  data response pulse
- dtim_valid  out  1  request pulse to dtim
- dtim_instr  out  1  1 = current request is an instruction fetch
- dtim_addr  out  32  request address
- dtim_wdata  out  32  request store data
- dtim_wstrb  out  4  request strobes; always 0 for fetches
- dtim_rdata  in  32  dtim read data
- dtim_ready  in  1  dtim response pulse

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- State: FSM IDLE/BUSY; pending slots islot{v,addr}, dslot{v,addr,wdata,wstrb}; owner (I/D); last_grant.
- Reset:
  - Forces state=IDLE, islot.v=dslot.v=0, last_grant=D.
  - Forces dtim_valid=0, dtim_instr=0, dtim_addr/wdata=0, dtim_wstrb=0.
  - imem_ready=dmem_ready=0.
  - A dtim_ready arriving after reset (stale transaction) is ignored: no requester ready.
- Capture: *_valid=1 at edge t sets the slot with the sampled fields.
  - Each requester has at most one outstanding request.
  - A pulse while that requester's slot is occupied and its response is not in the same cycle is dropped; slot contents are unchanged.
- Grant happens when state=IDLE, or when BUSY and dtim_ready=1 this cycle.
  - Candidates are occupied slots, including a request arriving this cycle (captured and granted at the same edge).
  - If both are candidates: ROUND_ROBIN=1 picks the one that is not last_grant; ROUND_ROBIN=0 picks D.
  - A grant sets owner and last_grant, clears that slot, and loads the dtim_* registers.
  - The grant drives dtim_valid=1 for exactly the next cycle; state becomes BUSY.
  - With no candidate, state becomes IDLE.
- Latency: request pulse in cycle t with arbiter IDLE -> dtim_valid in cycle t+1.
- Hold: dtim_addr/wdata/wstrb/instr stay stable from dtim_valid until dtim_ready.
- dtim_valid is 0 in all other cycles and is never asserted twice for one request.
- Response path is combinational and zero-cycle:
  - imem_ready = dtim_ready & BUSY & owner==I.
  - dmem_ready = dtim_ready & BUSY & owner==D.
  - imem_rdata = dmem_rdata = dtim_rdata.
- Back-to-back: on the dtim_ready cycle a pending request is granted, so dtim_valid is asserted the next cycle (no idle bubble).
  - A new pulse from the just-answered requester in that same ready cycle is accepted.
- dtim_ready while IDLE is ignored.
- Fetch requests always drive dtim_wstrb=0 and dtim_wdata=0.

Test Plan:
- Single load: dmem_valid at cycle 5, addr=0x100, wstrb=0 -> dtim_valid=1 at cycle 6 with addr 0x100, instr=0. dtim_ready at cycle 8 with rdata=0xDEADBEEF -> dmem_ready=1 with dmem_rdata=0xDEADBEEF at cycle 8; imem_ready stays 0.
- Contention, ROUND_ROBIN=1: imem addr 0x0 and dmem addr 0x200 pulse together at cycle 3 after reset (last_grant=D) -> instruction issued at cycle 4. Ready at cycle 5 -> data issued at cycle 6 with addr 0x200, wstrb=0xF store, wdata=0x12345678.
- Contention, ROUND_ROBIN=0: same stimulus -> data granted first at cycle 4, fetch at cycle 6 (after ready at cycle 5).
- Back-to-back fetch: imem pulse issued in the same cycle as its prior dtim_ready -> next dtim_valid one cycle later with the new addr 0x4; two imem_ready pulses, each with the correct rdata.
- Reset mid-operation: rst=1 for one cycle while BUSY with dslot occupied, then dtim_ready arrives -> no imem_ready/dmem_ready, dtim_valid stays 0, state IDLE.
- Protocol violation: a second dmem_valid with addr 0x300 while the first (0x200) is still pending -> only 0x200 reaches the dtim; a single dmem_ready is produced.
